parity_serial_rx: RTL and testbench

//  Serial receive end of the parity link. Deserialises one frame per transfer.

---
 rtl/parity_pkg.sv | 21 ++
 rtl/sync_2ff.sv | 26 ++
 rtl/parity_serial_rx.sv | 135 +++++++++++++
 tb/tb_parity_serial_rx.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
// rtl/parity_pkg.sv - shared parity link types, mode encodings and parity helper
package parity_pkg;

  localparam logic MODE_EVEN = 1'b0;
  localparam logic MODE_ODD  = 1'b1;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_WAIT_HI
  } rx_state_e;

  // Parity bit that makes (data + parity) match the requested mode; callers zero-extend.
  function automatic logic calc_parity(input logic [31:0] data, input logic mode);
    return (^data) ^ mode;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop single-bit synchroniser with selectable reset value
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/parity_serial_rx.sv
// rtl/parity_serial_rx.sv - serial frame receiver with parity and framing checks
module parity_serial_rx
  import parity_pkg::*;
#(
  parameter int DATA_W       = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_in,
  input  logic              mode,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  rx_state_e         r_state;
  rx_state_e         w_next;
  logic              w_rx_s;
  logic [CW-1:0]     r_cnt;
  logic [BW-1:0]     r_bit;
  logic [DATA_W-1:0] r_shift;
  logic              r_mode_q;
  logic              r_par_bit;
  logic              r_stop_bit;
  logic              r_fin;
  logic              w_start_ok;
  logic              w_data_smp;
  logic              w_par_smp;
  logic              w_stop_smp;
  logic              w_finish;

  sync_2ff #(.RST_VAL(1'b1)) u_rx_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (rx_in),
    .o_q   (w_rx_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= RX_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_start_ok = 1'b0;
    w_data_smp = 1'b0;
    w_par_smp  = 1'b0;
    w_stop_smp = 1'b0;
    w_finish   = 1'b0;
    case (r_state)
      RX_IDLE: if (!w_rx_s) w_next = RX_START;
      RX_START: begin
        if (r_cnt == HALF_M1) begin
          w_start_ok = !w_rx_s;
          w_next     = w_rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (r_cnt == FULL_M1) begin
          w_data_smp = 1'b1;
          if (r_bit == LAST_BIT) w_next = RX_PARITY;
        end
      end
      RX_PARITY: begin
        if (r_cnt == FULL_M1) begin
          w_par_smp = 1'b1;
          w_next    = RX_STOP;
        end
      end
      // Stop is sampled first; results are published on the following cycle.
      RX_STOP: begin
        if (r_fin) begin
          w_finish = 1'b1;
          w_next   = r_stop_bit ? RX_IDLE : RX_WAIT_HI;
        end else if (r_cnt == FULL_M1) begin
          w_stop_smp = 1'b1;
        end
      end
      RX_WAIT_HI: if (w_rx_s) w_next = RX_IDLE;
      default: w_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_mode_q   <= MODE_EVEN;
      r_par_bit  <= 1'b0;
      r_stop_bit <= 1'b1;
      r_fin      <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= w_finish;
      if ((w_next != r_state) || (r_cnt == FULL_M1) ||
          (r_state == RX_IDLE) || (r_state == RX_WAIT_HI)) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_next != r_state) r_bit <= '0;
      else if (w_data_smp)   r_bit <= r_bit + BW'(1);
      if (w_start_ok) r_mode_q <= mode;
      if (w_data_smp) r_shift <= {w_rx_s, r_shift[DATA_W-1:1]};
      if (w_par_smp) r_par_bit <= w_rx_s;
      if (w_stop_smp) begin
        r_stop_bit <= w_rx_s;
        r_fin      <= 1'b1;
      end
      if (w_finish) begin
        r_fin      <= 1'b0;
        data_out   <= r_shift;
        parity_err <= (calc_parity(32'(r_shift), r_mode_q) != r_par_bit);
        frame_err  <= ~r_stop_bit;
      end
    end
  end

  assign busy = (r_state != RX_IDLE) && (r_state != RX_START);

endmodule

// File: tb/tb_parity_serial_rx.sv
// tb/tb_parity_serial_rx.sv - randomized self-checking bench for parity_serial_rx
module tb_parity_serial_rx;

  localparam int DW  = 4;
  localparam int CPB = 4;
  localparam int LAT = (DW + 2) * CPB + CPB / 2 + 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rx_in;
  logic          mode;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          parity_err;
  logic          frame_err;
  logic          busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    logic [DW-1:0] data;
    logic          perr;
    logic          ferr;
    int            t;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  logic [DW-1:0] last_data = '0;
  logic          last_perr = 1'b0;
  logic          last_ferr = 1'b0;
  int            busy_hits;

  parity_serial_rx #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_in      (rx_in),
    .mode       (mode),
    .data_out   (data_out),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Scoreboard: every data_valid pulse must match the oldest expected frame, on time.
  always @(negedge clk) begin
    if (rst_n && data_valid) begin
      if (sb.size() == 0) begin
        check_eq("dv_with_no_frame", 32'(data_valid), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check_eq("data_out", 32'(data_out), 32'(mon_e.data));
        check_eq("parity_err", 32'(parity_err), 32'(mon_e.perr));
        check_eq("frame_err", 32'(frame_err), 32'(mon_e.ferr));
        check_eq("dv_latency", cyc, mon_e.t);
        last_data = mon_e.data;
        last_perr = mon_e.perr;
        last_ferr = mon_e.ferr;
      end
    end
  end

  task automatic drive_bit(input logic b, input logic tog, output int t);
    @(posedge clk);
    #1;
    rx_in = b;
    if (tog) mode = ~mode;
    t = cyc;
    repeat (CPB - 1) @(posedge clk);
  endtask

  task automatic idle_bits(input int n);
    int t;
    for (int i = 0; i < n; i++) drive_bit(1'b1, 1'b0, t);
  endtask

  // tog_idx: frame bit index (start=0) at which mode flips; -1 for none.
  task automatic send_frame(input logic [DW-1:0] d, input logic p, input logic s, input int tog_idx);
    int   t;
    exp_t e;
    drive_bit(1'b0, 1'b0, t);
    e.data = d;
    e.perr = ((($countones(d) + int'(p)) % 2) != int'(mode));
    e.ferr = !s;
    e.t    = t + 1 + LAT;
    sb.push_back(e);
    for (int i = 0; i < DW; i++) drive_bit(d[i], (tog_idx == i + 1), t);
    drive_bit(p, (tog_idx == DW + 1), t);
    drive_bit(s, (tog_idx == DW + 2), t);
  endtask

  task automatic check_held(input string tag);
    @(negedge clk);
    check_eq({tag, "_data"}, 32'(data_out), 32'(last_data));
    check_eq({tag, "_perr"}, 32'(parity_err), 32'(last_perr));
    check_eq({tag, "_ferr"}, 32'(frame_err), 32'(last_ferr));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int            t;
    logic [DW-1:0] rd;
    logic          rp;
    logic          rs;
    int            rtog;

    rst_n = 1'b0;
    rx_in = 1'b1;
    mode  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_data", 32'(data_out), 32'd0);
    check_eq("rst_dv", 32'(data_valid), 32'd0);
    check_eq("rst_perr", 32'(parity_err), 32'd0);
    check_eq("rst_ferr", 32'(frame_err), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle_bits(2);

    mode = 1'b1;
    send_frame(4'b1110, 1'b0, 1'b1, -1);
    idle_bits(2);
    send_frame(4'b1100, 1'b0, 1'b1, -1);
    idle_bits(2);
    mode = 1'b0;
    send_frame(4'b1100, 1'b0, 1'b1, -1);
    idle_bits(2);

    // Stop bit low, line held low: no retrigger, still busy until released.
    send_frame(4'b1001, 1'b0, 1'b0, -1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check_eq("held_low_busy", 32'(busy), 32'd1);
    idle_bits(2);
    @(negedge clk);
    check_eq("released_busy", 32'(busy), 32'd0);
    check_held("after_break");
    send_frame(4'b0111, 1'b0, 1'b1, -1);
    idle_bits(2);

    // Single-cycle glitch on the line.
    @(posedge clk);
    #1 rx_in = 1'b0;
    @(posedge clk);
    #1 rx_in = 1'b1;
    busy_hits = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) busy_hits++;
    end
    check_eq("glitch_busy_cycles", busy_hits, 0);
    check_held("after_glitch");

    // Reset in the middle of data bit 2.
    drive_bit(1'b0, 1'b0, t);
    drive_bit(1'b1, 1'b0, t);
    drive_bit(1'b0, 1'b0, t);
    @(posedge clk);
    #1 rx_in = 1'b1;
    @(negedge clk);
    check_eq("mid_frame_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_eq("async_rst_data", 32'(data_out), 32'd0);
    check_eq("async_rst_perr", 32'(parity_err), 32'd0);
    check_eq("async_rst_ferr", 32'(frame_err), 32'd0);
    check_eq("async_rst_busy", 32'(busy), 32'd0);
    check_eq("async_rst_dv", 32'(data_valid), 32'd0);
    last_data = '0;
    last_perr = 1'b0;
    last_ferr = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle_bits(1);
    check_held("post_reset");
    send_frame(4'b1010, 1'b1, 1'b1, -1);
    idle_bits(2);

    // Back-to-back frames, mode flipped during the first one.
    mode = 1'b1;
    send_frame(4'b1110, 1'b0, 1'b1, 3);
    send_frame(4'b0101, 1'b0, 1'b1, -1);
    idle_bits(2);

    for (int n = 0; n < 40; n++) begin
      rd   = DW'($urandom);
      rp   = 1'($urandom);
      rs   = ($urandom_range(0, 4) != 0);
      rtog = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, DW + 2)) : -1;
      mode = 1'($urandom);
      send_frame(rd, rp, rs, rtog);
      if (!rs) begin
        repeat ($urandom_range(0, 10)) @(posedge clk);
        idle_bits(1);
      end else begin
        idle_bits($urandom_range(0, 2));
      end
    end

    for (int i = 0; i < 200 && sb.size() > 0; i++) @(posedge clk);
    check_eq("frames_outstanding", sb.size(), 0);
    idle_bits(2);
    @(negedge clk);
    check_eq("final_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
